// File: rtl/mem_master.sv
// mem_master: load/store initiator between the CPU request port and a word RAM.
// Sub-word stores are read-modify-write; loads extract and sign/zero extend a lane.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses complete
// with rsp_err=1 and no RAM access; when undefined, surplus low address bits are ignored.
module mem_master #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_read_ack
);

  typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWr, StResp} state_e;

  state_e state_q, state_d;

  logic              we_q;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              accept;
  logic              misaligned;
  logic [31:0]       shifted;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  // Ready is gated by rst_n so it stays low while reset is held.
  assign req_ready = rst_n & (state_q == StIdle);
  assign accept    = req_valid & req_ready;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign mem_read       = (state_q == StRdReq);
  assign mem_write      = (state_q == StWr);
  assign rsp_valid      = (state_q == StResp);
  assign rsp_rdata      = rdata_q;
  assign rsp_err        = err_q;
  assign mem_read_addr  = addr_q[ADDR_W+1:2];
  assign mem_write_addr = addr_q[ADDR_W+1:2];
  assign mem_wdata      = wdata_q;

  // State register; async reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; acks outside StRdWait are ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (misaligned) begin
            state_d = StResp;
          end else if (req_we && req_size[1]) begin
            state_d = StWr;
          end else begin
            state_d = StRdReq;
          end
        end
      end
      StRdReq:  state_d = StRdWait;
      StRdWait: if (mem_read_ack) state_d = we_q ? StWr : StResp;
      StWr:     state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores (little-endian).
  always_comb begin
    shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (size_q)
      2'b00:   load_data = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{~unsigned_q & half_sel[15]}}, half_sel};
      default: load_data = mem_rdata;
    endcase
    merged = mem_rdata;
    if (size_q == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (size_q == 2'b01) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  // Request latch and result/write-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else if (accept) begin
      we_q       <= req_we;
      addr_q     <= req_addr;
      size_q     <= req_size;
      unsigned_q <= req_unsigned;
      wdata_q    <= req_wdata;
      rdata_q    <= 32'h0;
      err_q      <= misaligned;
    end else if ((state_q == StRdWait) && mem_read_ack) begin
      if (we_q) begin
        wdata_q <= merged;
      end else begin
        rdata_q <= load_data;
      end
    end
  end

endmodule
